tick_debouncer: RTL

Debounces a noisy single-bit level input, such as a push-button or switch contact. Stability is measured in ticks, not clock cycles. It sits directly downstream of the team's periodic pulse generator: the generator's one-cycle `pulse` output drives this block's `tick` input. Outputs are a clean registered level plus one-cycle rise/fall event strobes for downstream control logic.

---
 rtl/tick_debouncer_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/tick_debouncer.sv | 114 +++++++++++
 3 files changed

// File: rtl/tick_debouncer_pkg.sv
// Shared types and limits for the tick-based debouncer.
package tick_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  localparam int STABLE_TICKS_MAX = 255;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to a chosen value.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tick_debouncer.sv
// Debounces a single-bit level, measuring stability in ticks; emits rise/fall strobes.
// Define TICK_DEBOUNCER_SYNC_EN to put a 2-flop synchronizer in front of btn_in.
module tick_debouncer
  import tick_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 4,
  parameter logic INIT_LEVEL   = 1'b0,
  localparam int  CNT_WIDTH    = $clog2(STABLE_TICKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(STABLE_TICKS - 1);
  localparam state_t               STATE_INIT = INIT_LEVEL ? ST_HI : ST_LO;

  logic                 btnS;
  state_t               state, stateNext;
  logic [CNT_WIDTH-1:0] cnt, cntNext;
  logic                 levelNext, riseNext, fallNext;

`ifdef TICK_DEBOUNCER_SYNC_EN
  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btnS)
  );
`else
  assign btnS = btn_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STATE_INIT;
      cnt   <= '0;
      level <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      level <= levelNext;
      rise  <= riseNext;
      fall  <= fallNext;
    end
  end

  // A tick on the edge that enters a check is deliberately not counted.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    levelNext = level;
    riseNext  = 1'b0;
    fallNext  = 1'b0;
    case (state)
      ST_LO: begin
        if (btnS) begin
          stateNext = CHK_HI;
          cntNext   = '0;
        end
      end
      ST_HI: begin
        if (!btnS) begin
          stateNext = CHK_LO;
          cntNext   = '0;
        end
      end
      CHK_HI: begin
        if (!btnS) begin
          stateNext = ST_LO;
          cntNext   = '0;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            stateNext = ST_HI;
            cntNext   = '0;
            levelNext = 1'b1;
            riseNext  = 1'b1;
          end else begin
            cntNext = cnt + CNT_WIDTH'(1);
          end
        end
      end
      CHK_LO: begin
        if (btnS) begin
          stateNext = ST_HI;
          cntNext   = '0;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            stateNext = ST_LO;
            cntNext   = '0;
            levelNext = 1'b0;
            fallNext  = 1'b1;
          end else begin
            cntNext = cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        stateNext = STATE_INIT;
        cntNext   = '0;
      end
    endcase
  end

endmodule
